// File: rtl/async_ring_pkg.sv
// Shared types and constants for the clocked monitors that sit beside the self-timed ring.
package async_ring_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_HI = 3'd1,
    ST_REQ_LO = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } ring_start_state_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Four-phase return-to-zero handshake phases, in protocol order.
  localparam logic [1:0] HS_REQ_RISE = 2'd0;
  localparam logic [1:0] HS_ACK_RISE = 2'd1;
  localparam logic [1:0] HS_REQ_FALL = 2'd2;
  localparam logic [1:0] HS_ACK_FALL = 2'd3;

  // Phase that the (req, ack) pair is waiting to complete.
  function automatic logic [1:0] hs_phase(input logic req, input logic ack);
    if (req && !ack)      return HS_ACK_RISE;
    else if (req && ack)  return HS_REQ_FALL;
    else if (!req && ack) return HS_ACK_FALL;
    else                  return HS_REQ_RISE;
  endfunction

endpackage

// File: rtl/async_bit_sync.sv
// Single-bit flop-chain synchronizer for asynchronous ring signals into clk_i.
// Latency STAGES cycles; no backpressure.
module async_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_ring_starter.sv
// Launches the ring's single token with a four-phase handshake, then counts retirements and watches for a stall.
// Outputs registered; ack/retire see SYNC_STAGES+1 cycles latency; no backpressure, the ring's ack paces launch.
module async_ring_starter
  import async_ring_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic             retire_req_i,
  output logic             req_start_o,
  output logic             busy_o,
  output logic             running_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  ring_start_state_e state_q, state_d;
  logic              ack_s, ret_s, ret_q, start_q;
  logic              start_rise, ret_rise, wd_hit;
  logic [WD_W-1:0]   wd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_d, busy_d, run_d, fault_d;

  async_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ack_i),
    .q_o    (ack_s)
  );

  async_bit_sync #(.STAGES(SYNC_STAGES)) u_retire_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (retire_req_i),
    .q_o    (ret_s)
  );

  assign start_rise = start_i & ~start_q;
  assign ret_rise   = ret_s & ~ret_q;
  assign wd_hit     = (wd_q == WD_MAX);

  // Outputs are flopped from the next state so req_start_o never glitches into the ring.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      req_start_o <= 1'b0;
      busy_o      <= 1'b0;
      running_o   <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_start_o <= req_d;
      busy_o      <= busy_d;
      running_o   <= run_d;
      fault_o     <= fault_d;
    end
  end

  // A handshake transition takes priority over a coincident watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_rise && !ack_s) state_d = ST_REQ_HI;
      ST_REQ_HI: if (ack_s)                state_d = ST_REQ_LO;
                 else if (wd_hit)          state_d = ST_FAULT;
      ST_REQ_LO: if (!ack_s)               state_d = ST_RUN;
                 else if (wd_hit)          state_d = ST_FAULT;
      ST_RUN:    if (!ret_rise && wd_hit)  state_d = ST_FAULT;
      ST_FAULT:                            state_d = ST_FAULT;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d   = (state_d == ST_REQ_HI);
    busy_d  = (state_d == ST_REQ_HI) || (state_d == ST_REQ_LO);
    run_d   = (state_d == ST_RUN);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      start_q <= start_i;
      ret_q   <= ret_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (state_d != state_q) begin
      wd_q <= '0;
    end else if (state_q == ST_RUN && ret_rise) begin
      wd_q <= '0;
    end else if (state_q == ST_REQ_HI || state_q == ST_REQ_LO || state_q == ST_RUN) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == ST_RUN && ret_rise && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign retired_o = cnt_q;

endmodule

// File: tb/tb_async_ring_starter.sv
// Directed bench for async_ring_starter: launch table, retirement saturation, watchdog, reset and ignored starts.
module tb_async_ring_starter;
  import async_ring_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       ack_i;
  logic       retire_req_i;
  logic       req_start_o;
  logic       busy_o;
  logic       running_o;
  logic       fault_o;
  logic [2:0] retired_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  async_ring_starter #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (3)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .ack_i        (ack_i),
    .retire_req_i (retire_req_i),
    .req_start_o  (req_start_o),
    .busy_o       (busy_o),
    .running_o    (running_o),
    .fault_o      (fault_o),
    .retired_o    (retired_o)
  );

  typedef struct {
    logic       start;
    logic       ack;
    logic       ret;
    logic       req;
    logic       busy;
    logic       run;
    logic       fault;
    logic [2:0] retired;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; each step crosses one rising edge and lands on the next falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  task automatic check_outs(input string name, input logic req, input logic busy,
                            input logic run, input logic fault);
    check(name, {28'd0, req_start_o, busy_o, running_o, fault_o}, {28'd0, req, busy, run, fault});
  endtask

  task automatic retire_pulse();
    retire_req_i = 1'b1;
    cyc(4);
    retire_req_i = 1'b0;
    cyc(4);
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic s, input logic a, input logic r,
                         input logic req, input logic busy, input logic run, input logic [2:0] ret);
    vt[i].start = s;   vt[i].ack = a;     vt[i].ret = r;
    vt[i].req = req;   vt[i].busy = busy; vt[i].run = run;
    vt[i].fault = 1'b0; vt[i].retired = ret;
  endtask

  initial begin
    //          s  a  r  req busy run retired
    set_vec(0,  1, 0, 0, 1,  1,   0,  3'd0);
    set_vec(1,  0, 0, 0, 1,  1,   0,  3'd0);
    set_vec(2,  0, 1, 0, 1,  1,   0,  3'd0);
    set_vec(3,  0, 1, 0, 1,  1,   0,  3'd0);
    set_vec(4,  0, 1, 0, 0,  1,   0,  3'd0);
    set_vec(5,  0, 0, 0, 0,  1,   0,  3'd0);
    set_vec(6,  0, 0, 0, 0,  1,   0,  3'd0);
    set_vec(7,  0, 0, 0, 0,  0,   1,  3'd0);
    set_vec(8,  0, 0, 1, 0,  0,   1,  3'd0);
    set_vec(9,  0, 0, 1, 0,  0,   1,  3'd0);
    set_vec(10, 0, 0, 1, 0,  0,   1,  3'd1);
    set_vec(11, 0, 0, 1, 0,  0,   1,  3'd1);
    for (int i = 12; i < 16; i++) set_vec(i, 0, 0, 0, 0, 0, 1, 3'd1);

    rst_ni = 1'b0; start_i = 1'b0; ack_i = 1'b0; retire_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_outs("reset_outs", 0, 0, 0, 0);
    check("reset_retired", {29'd0, retired_o}, 32'd0);
    rst_ni = 1'b1;
    cyc(3);
    check_outs("idle_outs", 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      start_i = vt[i].start; ack_i = vt[i].ack; retire_req_i = vt[i].ret;
      cyc(1);
      check($sformatf("vec%0d", i),
            {25'd0, req_start_o, busy_o, running_o, fault_o, retired_o},
            {25'd0, vt[i].req, vt[i].busy, vt[i].run, vt[i].fault, vt[i].retired});
    end

    for (int i = 0; i < 6; i++) retire_pulse();
    check("retired_7", {29'd0, retired_o}, 32'd7);
    start_pulse();
    check_outs("restart_in_run", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) retire_pulse();
    check("retired_sat", {29'd0, retired_o}, 32'd7);

    // Last rise was 5 steps before the pulse ended; the watchdog fires 16 edges after it.
    cyc(10);
    check_outs("run_pre_timeout", 0, 0, 1, 0);
    cyc(1);
    check_outs("run_timeout", 0, 0, 0, 1);
    retire_pulse();
    check("fault_frozen_cnt", {29'd0, retired_o}, 32'd7);
    check_outs("fault_sticky", 0, 0, 0, 1);

    rst_ni = 1'b0;
    #1;
    check_outs("fault_reset", 0, 0, 0, 0);
    check("fault_reset_cnt", {29'd0, retired_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1);

    ack_i = 1'b1;
    cyc(3);
    start_pulse();
    check_outs("start_ack_high", 0, 0, 0, 0);
    cyc(3);
    check_outs("start_ack_high_hold", 0, 0, 0, 0);
    ack_i = 1'b0;
    cyc(3);

    start_pulse();
    check_outs("launch2_req", 1, 1, 0, 0);
    cyc(2);
    #2 rst_ni = 1'b0;
    #1;
    check_outs("reset_in_req_hi", 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1);

    start_pulse();
    check_outs("relaunch_req", 1, 1, 0, 0);
    cyc(4);
    ack_i = 1'b1;
    cyc(2);
    check_outs("relaunch_ack_sync", 1, 1, 0, 0);
    cyc(1);
    check_outs("relaunch_req_low", 0, 1, 0, 0);
    cyc(4);
    ack_i = 1'b0;
    cyc(2);
    check_outs("relaunch_ackn_sync", 0, 1, 0, 0);
    cyc(1);
    check_outs("relaunch_run", 0, 0, 1, 0);

    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1);
    start_pulse();
    check_outs("noack_req", 1, 1, 0, 0);
    cyc(15);
    check_outs("noack_pre_timeout", 1, 1, 0, 0);
    cyc(1);
    check_outs("noack_timeout", 0, 0, 0, 1);
    cyc(5);
    check_outs("noack_fault_sticky", 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/async_ring_starter.md
# async_ring_starter

Clocked bootstrap stage directly upstream of the asynchronous controller ring: it launches the single initial token into the PC-advance fork (its `req_start` input) with a four-phase handshake. After launch it observes the register-file write controller's request to count retired instructions, and flags a stuck ring via a watchdog. It is the only clocked logic touching the ring and bridges the synchronous test/SoC domain to the self-timed core.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of every asynchronous-input synchronizer (legal ≥2).
- `TIMEOUT_CYCLES`, default 1024: clk_i cycles allowed per handshake phase, and between retirements in RUN, before FAULT.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk_i`  in  1  sole clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  synchronous to clk_i; rising edge requests token launch.
- `ack_i`  in  1  asynchronous; ack from PC-advance fork (`ack_in_o`).
- `retire_req_i`  in  1  asynchronous; register-file write controller `req_out_o`.
- `req_start_o`  out  1  token request ORed into the PC-advance fork request.
- `busy_o`  out  1  launch handshake in progress.
- `running_o`  out  1  token launched, ring live.
- `fault_o`  out  1  watchdog expired (sticky until reset).
- `retired_o`  out  CNT_W  retired-instruction count.

## Operation
- Synchronizers: `ack_i` and `retire_req_i` each pass through SYNC_STAGES flops; only synchronized versions are used internally.
- Four-phase return-to-zero protocol: req↑, ack↑, req↓, ack↓.
- FSM states: IDLE, REQ_HI, REQ_LO, RUN, FAULT.
  - IDLE: req_start_o=0. Rising edge of start_i with ack_s=0 → REQ_HI. Edge while ack_s=1 is ignored.
  - REQ_HI: req_start_o=1, busy_o=1; ack_s=1 → REQ_LO.
  - REQ_LO: req_start_o=0, busy_o=1; ack_s=0 → RUN.
  - RUN: running_o=1, req_start_o held 0 permanently; further start_i edges ignored.
  - FAULT: fault_o=1, req_start_o=0; exit only by reset.
- Watchdog: counter clears on every state entry and on every retirement edge in RUN; increments otherwise in REQ_HI/REQ_LO/RUN; reaching TIMEOUT_CYCLES-1 → FAULT next cycle. Disabled in IDLE/FAULT.
- Retirement: a rising edge of the synchronized retire_req in RUN increments retired_o by 1, saturating at 2^CNT_W-1. Edges outside RUN are not counted. The count freezes in FAULT.
- All outputs are registered (state-decoded from flops, no combinational paths from inputs). This prevents glitches on req_start_o into the self-timed ring.

## Timing
- Reset values: state IDLE, req_start_o=0, busy_o=0, running_o=0, fault_o=0, retired_o=0, synchronizers 0, watchdog 0.
- start_i edge at cycle n → req_start_o=1 at n+1.
- ack_i↑ → req_start_o↓ after SYNC_STAGES+1 cycles. ack_i↓ → running_o=1 after SYNC_STAGES+1 cycles.
- retire_req_i↑ → retired_o increments after SYNC_STAGES+1 cycles (edge detect adds one flop). Retire pulses narrower than SYNC_STAGES+1 cycles high or low are not guaranteed to count. The ring is constrained (controller DELAY) to respect this.
- Simultaneous watchdog expiry and ack_s transition in the same cycle: the transition wins, and the watchdog clears.
- Reset asserted mid-operation: all outputs drop asynchronously the same instant. req_start_o falls without waiting for ack, and the ring is reset by the same rst_ni.

## Structure
- Package `async_ring_pkg`: state enum `ring_start_state_e`, default constants for SYNC_STAGES/TIMEOUT_CYCLES, and the handshake-phase localparams shared with other clocked ring monitors.
- Sub-module `async_bit_sync` (parameter STAGES, async active-low reset to 0) is instantiated twice. The FSM, watchdog, and counter stay in the top module.

## Test plan
- Reset then start_i pulse at cycle 10; model acks ack_i↑ 5 cycles after req, ↓ 5 after req↓ → req_start_o high cycles 11–18, running_o=1 at cycle 27, busy_o low thereafter.
- In RUN, apply 7 retire_req_i pulses (4 high/4 low) → retired_o=7; a second start_i pulse leaves req_start_o=0.
- Never assert ack_i, TIMEOUT_CYCLES=16 → fault_o=1 at cycle 17 after REQ_HI entry; req_start_o=0; stays until reset.
- CNT_W=3, apply 10 retirements → retired_o saturates at 7.
- Assert rst_ni low while in REQ_HI → req_start_o, busy_o drop immediately; after release, a fresh start relaunches normally.
- start_i edge while ack_i held high → remains IDLE, req_start_o=0.
